// File: rtl/motion_executor.sv
// rtl/motion_executor.sv - driving-mode command responder: motor/light outputs with timed turns
// Optional macro TURN_BLINK_EN: blink the active turn light every BLINK_TICKS ticks during TURN.
module motion_executor #(
   parameter int TICK_DIV     = 2000000,
   parameter int TURN_TICKS   = 200,
   parameter int SETTLE_TICKS = 10,
   parameter int BLINK_TICKS  = 25
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       power,
   input  logic       cmd_valid,
   input  logic [3:0] cmd,
   output logic       cmd_ready,
   output logic       done,
   output logic       busy,
   output logic       move_forward_signal,
   output logic       move_backward_signal,
   output logic       turn_left_signal,
   output logic       turn_right_signal,
   output logic       move_forward_light,
   output logic       move_backward_light,
   output logic       turn_left_light,
   output logic       turn_right_light
);

   localparam int DW = $clog2(TICK_DIV + 1);
   localparam int TW = $clog2(TURN_TICKS + 1);
   localparam int SW = $clog2(SETTLE_TICKS + 1);
   localparam int BW = $clog2(BLINK_TICKS + 1);

`ifdef TURN_BLINK_EN
   localparam logic BLINK_EN = 1'b1;
`else
   localparam logic BLINK_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, FWD, BACK, TURN, SETTLE} state_t;
   typedef enum logic [1:0] {P_NONE, P_FWD, P_BACK} pend_t;

   state_t        state_q, state_d;
   pend_t         pend_q, pend_d;
   logic          dir_q, dir_d;          // 0 = left, 1 = right
   logic [DW-1:0] div_q, div_d;
   logic [TW-1:0] turn_cnt_q, turn_cnt_d;
   logic [SW-1:0] settle_cnt_q, settle_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;
   logic          done_q, done_d;
   logic          fwd_q, fwd_d, back_q, back_d, left_q, left_d, right_q, right_d;
   logic          fl_q, bl_q, ll_q, rl_q, ll_d, rl_d;
   logic          tick, accept;

   assign cmd_ready = power && (state_q == IDLE || state_q == FWD || state_q == BACK);
   assign busy      = (state_q == TURN) || (state_q == SETTLE);
   assign accept    = cmd_valid && cmd_ready;
   assign tick      = (div_q == DW'(TICK_DIV - 1));

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      dir_d        = dir_q;
      div_d        = tick ? '0 : div_q + DW'(1);
      turn_cnt_d   = turn_cnt_q;
      settle_cnt_d = settle_cnt_q;
      blink_cnt_d  = blink_cnt_q;
      blink_d      = blink_q;
      done_d       = 1'b0;

      case (state_q)
         IDLE, FWD, BACK: begin
            if (accept) begin
               pend_d = P_NONE;
               case (cmd)
                  4'b0001: begin
                     if (state_q == BACK) begin
                        state_d = IDLE;
                        pend_d  = P_FWD;
                     end else begin
                        state_d = FWD;
                     end
                  end
                  4'b0010: begin
                     if (state_q == FWD) begin
                        state_d = IDLE;
                        pend_d  = P_BACK;
                     end else begin
                        state_d = BACK;
                     end
                  end
                  4'b0100, 4'b1000: begin
                     state_d     = TURN;
                     dir_d       = cmd[3];
                     turn_cnt_d  = '0;
                     blink_cnt_d = '0;
                     blink_d     = 1'b1;
                  end
                  default: state_d = IDLE;
               endcase
            end else if (state_q == IDLE && pend_q != P_NONE) begin
               // second half of a direct reversal: one stopped cycle has elapsed
               state_d = (pend_q == P_FWD) ? FWD : BACK;
               pend_d  = P_NONE;
            end
         end
         TURN: begin
            if (tick) begin
               if (turn_cnt_q == TW'(TURN_TICKS - 1)) begin
                  state_d      = SETTLE;
                  settle_cnt_d = '0;
               end else begin
                  turn_cnt_d = turn_cnt_q + TW'(1);
               end
               if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                  blink_cnt_d = '0;
                  blink_d     = ~blink_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + BW'(1);
               end
            end
         end
         SETTLE: begin
            if (tick) begin
               if (settle_cnt_q == SW'(SETTLE_TICKS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  settle_cnt_d = settle_cnt_q + SW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (!power) begin
         state_d      = IDLE;
         pend_d       = P_NONE;
         turn_cnt_d   = '0;
         settle_cnt_d = '0;
         blink_cnt_d  = '0;
         blink_d      = 1'b0;
         done_d       = 1'b0;
      end

      // outputs are registered from the next state so they track state_q exactly
      fwd_d   = (state_d == FWD);
      back_d  = (state_d == BACK);
      left_d  = (state_d == TURN) && !dir_d;
      right_d = (state_d == TURN) && dir_d;
      ll_d    = left_d && (blink_d || !BLINK_EN);
      rl_d    = right_d && (blink_d || !BLINK_EN);
   end

   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         pend_q       <= P_NONE;
         dir_q        <= 1'b0;
         div_q        <= '0;
         turn_cnt_q   <= '0;
         settle_cnt_q <= '0;
         blink_cnt_q  <= '0;
         blink_q      <= 1'b0;
         done_q       <= 1'b0;
         fwd_q        <= 1'b0;
         back_q       <= 1'b0;
         left_q       <= 1'b0;
         right_q      <= 1'b0;
         fl_q         <= 1'b0;
         bl_q         <= 1'b0;
         ll_q         <= 1'b0;
         rl_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         dir_q        <= dir_d;
         div_q        <= div_d;
         turn_cnt_q   <= turn_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_q      <= blink_d;
         done_q       <= done_d;
         fwd_q        <= fwd_d;
         back_q       <= back_d;
         left_q       <= left_d;
         right_q      <= right_d;
         fl_q         <= fwd_d;
         bl_q         <= back_d;
         ll_q         <= ll_d;
         rl_q         <= rl_d;
      end
   end

   assign done                 = done_q;
   assign move_forward_signal  = fwd_q;
   assign move_backward_signal = back_q;
   assign turn_left_signal     = left_q;
   assign turn_right_signal    = right_q;
   assign move_forward_light   = fl_q;
   assign move_backward_light  = bl_q;
   assign turn_left_light      = ll_q;
   assign turn_right_light     = rl_q;

endmodule

// File: tb/tb_motion_executor.sv
// tb/tb_motion_executor.sv - scoreboard bench for motion_executor (TICK_DIV=4, TURN_TICKS=3, SETTLE_TICKS=2)
module tb_motion_executor;

   logic       sys_clk = 1'b0;
   logic       rst, power, cmd_valid;
   logic [3:0] cmd;
   logic       cmd_ready, done, busy;
   logic       fwd, back, left, right, fl, bl, ll, rl;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;
   logic prev_f = 1'b0, prev_b = 1'b0;

   string       tag_q[$];
   logic [10:0] val_q[$];

   // {cmd_ready, busy, done, fwd, back, left, right, fwd_light, back_light, left_light, right_light}
   localparam logic [10:0] IDLE_V   = 11'b10000000000;
   localparam logic [10:0] FWD_V    = 11'b10010001000;
   localparam logic [10:0] BACK_V   = 11'b10001000100;
   localparam logic [10:0] RIGHT_V  = 11'b01000010001;
   localparam logic [10:0] LEFT_V   = 11'b01000100010;
   localparam logic [10:0] SETTLE_V = 11'b01000000000;
   localparam logic [10:0] DONE_V   = 11'b10100000000;
   localparam logic [10:0] OFF_V    = 11'b00000000000;
`ifdef TURN_BLINK_EN
   localparam logic [10:0] LMASK    = 11'h7FC;
`else
   localparam logic [10:0] LMASK    = 11'h7FF;
`endif

   motion_executor #(
      .TICK_DIV(4), .TURN_TICKS(3), .SETTLE_TICKS(2), .BLINK_TICKS(1)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .power(power), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_ready(cmd_ready), .done(done), .busy(busy),
      .move_forward_signal(fwd), .move_backward_signal(back),
      .turn_left_signal(left), .turn_right_signal(right),
      .move_forward_light(fl), .move_backward_light(bl),
      .turn_left_light(ll), .turn_right_light(rl)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [10:0] outs();
      return {cmd_ready, busy, done, fwd, back, left, right, fl, bl, ll, rl};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop(input logic [10:0] obs);
      if (val_q.size() == 0) begin
         check("sb_underflow", 32'(1), 32'(0));
      end else begin
         check(tag_q.pop_front(), 32'(obs), 32'(val_q.pop_front()));
      end
   endtask

   task automatic step(input string tag, input logic [10:0] exp);
      tag_q.push_back(tag);
      val_q.push_back(exp);
      @(posedge sys_clk); #1;
      sb_pop(outs());
   endtask

   task automatic send(input logic [3:0] c, input string tag, input logic [10:0] exp);
      cmd_valid = 1'b1;
      cmd       = c;
      step(tag, exp);
      cmd_valid = 1'b0;
   endtask

   // Follows a turn from its first TURN cycle to the done cycle, which is matched by the scoreboard.
   task automatic watch_turn(input logic [10:0] turn_v, output int tcnt, output int scnt,
                             output int lon, output int loff);
      logic [10:0] v;
      bit in_settle = 1'b0;
      bit fin = 1'b0;
      tcnt = 0; scnt = 0; lon = 0; loff = 0;
      for (int i = 0; i < 100 && !fin; i++) begin
         v = outs();
         if (((v ^ turn_v) & LMASK) == 11'd0 && !in_settle) begin
            tcnt++;
            if (v[1]) lon++; else loff++;
         end else if (v == SETTLE_V && tcnt > 0) begin
            in_settle = 1'b1;
            scnt++;
         end else begin
            sb_pop(v);
            fin = 1'b1;
         end
         if (!fin) begin
            @(posedge sys_clk); #1;
         end
      end
      if (!fin) check("turn_timeout", 32'(0), 32'(1));
   endtask

   always @(negedge sys_clk) begin
      if (mon_en) begin
         check("motor_mutex", 32'($countones({fwd, back, left, right}) <= 1), 32'(1));
         check("no_adjacent_reversal", 32'(!((prev_f && back) || (prev_b && fwd))), 32'(1));
         prev_f = fwd;
         prev_b = back;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tc, sc, lon, loff;
      rst = 1'b0; power = 1'b1; cmd_valid = 1'b1; cmd = 4'b0001;
      repeat (3) step("reset_state", IDLE_V);
      rst = 1'b0; cmd_valid = 1'b0;
      rst = 1'b1;
      step("post_reset_idle", IDLE_V);
      step("post_reset_idle2", IDLE_V);
      mon_en = 1'b1;

      send(4'b0001, "fwd", FWD_V);
      step("fwd_hold", FWD_V);
      send(4'b0000, "stop", IDLE_V);
      send(4'b0001, "fwd_again", FWD_V);
      send(4'b0011, "bad_code_stops", IDLE_V);

      // right turn, one-cycle command
      cmd_valid = 1'b1; cmd = 4'b1000;
      tag_q.push_back("right_done"); val_q.push_back(DONE_V);
      @(posedge sys_clk); #1;
      cmd_valid = 1'b0;
      watch_turn(RIGHT_V, tc, sc, lon, loff);
      check("right_turn_len", 32'(tc >= 8 && tc <= 16), 32'(1));
      check("right_settle_len", 32'(sc >= 4 && sc <= 12), 32'(1));
      step("right_single_done", IDLE_V);

      // left turn with forward held throughout: forward only after done
      cmd_valid = 1'b1; cmd = 4'b0100;
      tag_q.push_back("left_done"); val_q.push_back(DONE_V);
      @(posedge sys_clk); #1;
      cmd = 4'b0001;
      watch_turn(LEFT_V, tc, sc, lon, loff);
      check("left_turn_len", 32'(tc >= 8 && tc <= 16), 32'(1));
      check("left_settle_len", 32'(sc >= 4 && sc <= 12), 32'(1));
`ifdef TURN_BLINK_EN
      check("left_light_blinks", 32'(lon > 0 && loff > 0), 32'(1));
`else
      check("left_light_steady", 32'(lon), 32'(tc));
`endif
      step("fwd_after_done", FWD_V);
      cmd_valid = 1'b0;

      // direct reversals
      send(4'b0010, "rev_fb_gap", IDLE_V);
      step("rev_fb_back", BACK_V);
      step("rev_fb_hold", BACK_V);
      send(4'b0001, "rev_bf_gap", IDLE_V);
      step("rev_bf_fwd", FWD_V);
      send(4'b0000, "stop2", IDLE_V);

      // power drop mid-turn
      send(4'b0100, "pwr_turn_entry", LEFT_V);
      repeat (5) @(posedge sys_clk);
      #1;
      power = 1'b0;
      step("pwr_off", OFF_V);
      cmd_valid = 1'b1; cmd = 4'b0001;
      repeat (3) step("pwr_off_hold", OFF_V);
      cmd_valid = 1'b0;
      power = 1'b1;
      step("pwr_on_idle", IDLE_V);
      repeat (15) step("pwr_no_done", IDLE_V);

      if (val_q.size() != 0) check("sb_leftover", 32'(val_q.size()), 32'(0));
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/motion_executor.md
Name: motion_executor

Overview:
- Responder side of the driving-mode command path: accepts moving-state commands (forward / stop / turn left / turn right / backward) from the mode FSMs and drives the car's motor-control and indicator-light outputs.
- Times the turn manoeuvres itself and reports completion back to the initiator with a done pulse.
- Sits between the semi-auto/auto decision FSMs and the car-simulator output pins.

Parameters:
- TICK_DIV, 2000000, sys_clk cycles per 20 ms tick (benches use 4).
- TURN_TICKS, 200, ticks a 90-degree turn output is held.
- SETTLE_TICKS, 10, ticks of forced stop after a turn before done is reported.
- BLINK_TICKS, 25, ticks per half-period of the turn-light blink (optional feature only).

Ports:
- sys_clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- power  in  1  car power; 0 forces idle
- cmd_valid  in  1  command present
- cmd  in  4  0001 forward, 0000 stop, 0100 left, 1000 right, 0010 backward
- cmd_ready  out  1  executor can accept a command this cycle
- done  out  1  one-cycle pulse at end of turn/settle
- busy  out  1  high in TURN or SETTLE
- move_forward_signal  out  1  motor forward
- move_backward_signal  out  1  motor backward
- turn_left_signal  out  1  steer left
- turn_right_signal  out  1  steer right
- move_forward_light, move_backward_light, turn_left_light, turn_right_light  out  1 each  indicator lights

Behaviour:
- Reset (rst==0 at a sys_clk edge): state IDLE; tick divider, turn counter and settle counter cleared; all outputs 0 except cmd_ready=1.
- Tick: divider counts 0..TICK_DIV-1. tick is high for one cycle when the count equals TICK_DIV-1, then the count wraps to 0. The divider free-runs regardless of state.
- States: IDLE(stop), FWD, BACK, TURN, SETTLE.
- cmd_ready = 1 in IDLE, FWD and BACK; 0 in TURN and SETTLE. A command is accepted on a cycle with cmd_valid and cmd_ready; the state changes on the next edge.
- Command decode on accept:
  - 0001 -> FWD
  - 0010 -> BACK
  - 0000 -> IDLE
  - 0100 -> TURN, direction left latched
  - 1000 -> TURN, direction right latched
  - Any other code -> IDLE (treated as stop). No error output.
- FWD and BACK persist until a new command is accepted.
- Direct reversal: FWD->BACK or BACK->FWD first passes through IDLE for exactly one cycle, so forward and backward are never high together on adjacent cycles. The pending direction is applied automatically with no re-handshake.
- TURN:
  - Turn counter clears on entry and increments on each tick.
  - When the counter reaches TURN_TICKS-1 and a tick occurs, go to SETTLE.
  - Turn duration is TURN_TICKS ticks, with phase error of at most one tick.
- SETTLE:
  - All motor outputs 0; settle counter increments on tick.
  - After SETTLE_TICKS ticks -> IDLE, with done=1 for the single cycle of that transition edge.
- Output mapping (registered, 1-cycle latency from state):
  - FWD: forward=1
  - BACK: backward=1
  - TURN: turn_left_signal or turn_right_signal per latched direction
  - All others 0
  - Each light mirrors its motor signal.
- cmd_valid during TURN/SETTLE is ignored; no queueing.
- power==0 (checked after reset, overrides everything):
  - Next state IDLE; an in-progress turn is aborted with no done pulse.
  - Counters cleared; cmd_ready=0 while power==0.
- Mutual exclusion: at most one of the four motor signals is high on any cycle.
- Reset mid-turn: identical to reset from idle. The latched direction is cleared to left.

Optional Feature:
- Macro TURN_BLINK_EN.
- Defined:
  - During TURN, the active turn light toggles every BLINK_TICKS ticks, starting high on TURN entry.
  - In SETTLE the light is forced 0.
  - Motor signals are unaffected.
- Undefined:
  - Turn lights are steady mirrors of the turn signals.
  - BLINK_TICKS is unused.

Test Plan:
- Reset: rst=0 for 3 cycles with cmd_valid=1, cmd=0001 -> all outputs 0, cmd_ready=1. After release, the state is IDLE until a command is accepted.
- Forward then stop (TICK_DIV=4): accept 0001 -> move_forward_signal=1 and light=1 one cycle later. Accept 0000 -> both 0 one cycle later; cmd_ready stays 1.
- Right turn (TICK_DIV=4, TURN_TICKS=3, SETTLE_TICKS=2):
  - Accept 1000 -> turn_right_signal high about 12 cycles (±4).
  - Then about 8 cycles of all-zero motor outputs with busy=1 and cmd_ready=0.
  - Then done pulses exactly once and cmd_ready returns to 1.
- Command during turn: cmd_valid=1, cmd=0001 held throughout TURN -> ignored. FWD is entered only on the first cycle after done when cmd_ready=1.
- Reversal: in FWD accept 0010 -> one cycle with all motor outputs 0, then backward=1. Forward and backward are never high together.
- Power drop mid-turn: power=0 at turn tick 1 -> all outputs 0 next cycle, no done pulse. Restoring power gives IDLE with cmd_ready=1. With TURN_BLINK_EN defined and BLINK_TICKS=1, turn_left_light toggles every tick during a left turn.
